// File: rtl/bottle_alarm_pkg.sv
// Shared types and the fixed alarm melody for bottle_alarm.
// Each note entry holds a tone half-period in clock cycles and a duration in ticks.
package bottle_alarm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } state_t;

  typedef struct packed {
    logic [15:0] half_div;
    logic [3:0]  dur;
  } note_t;

  localparam int NUM_NOTES = 8;

  // half_div == 0 marks a rest
  localparam note_t [0:NUM_NOTES-1] MELODY = '{
    '{16'd191, 4'd2},
    '{16'd170, 4'd2},
    '{16'd151, 4'd2},
    '{16'd143, 4'd2},
    '{16'd127, 4'd2},
    '{16'd113, 4'd2},
    '{16'd101, 4'd2},
    '{16'd0,   4'd4}
  };

endpackage

// File: rtl/alarm_tone_gen.sv
// Clearable square-wave generator: tone toggles every half_div enabled cycles, first toggle
// half_div cycles after clear; half_div == 0 holds the tone low. No backpressure.
module alarm_tone_gen (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [15:0] half_div_i,
  output logic        tone_o
);

  logic [15:0] cnt_q, cnt_d;
  logic        tone_q, tone_d;

  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    if (clr_i) begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end else if (en_i && (half_div_i != 16'd0)) begin
      if (cnt_q == half_div_i - 16'd1) begin
        cnt_d  = '0;
        tone_d = ~tone_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  assign tone_o = tone_q;

endmodule

// File: rtl/bottle_alarm.sv
// Plays the 8-note fill alarm on start; stop/RST abort to IDLE on the next edge, mute gates Speaker only.
// Optional ALARM_REPEAT_EN: repeat_i high at the end of note 7 loops back through a gap to note 0.
module bottle_alarm
  import bottle_alarm_pkg::*;
#(
  parameter int TICK_DIV  = 50000,
  parameter int GAP_TICKS = 2
) (
  input  logic       CLK_org,
  input  logic       RST,
  input  logic       start,
  input  logic       stop,
  input  logic       mute,
  input  logic       repeat_i,
  output logic       Speaker,
  output logic       busy,
  output logic [2:0] note_idx
);

  localparam int              CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]   CYC_LAST = CW'(TICK_DIV - 1);
  localparam logic [7:0]      GAP_LEN  = 8'(GAP_TICKS);

  state_t        state_q, state_d;
  logic [2:0]    note_q, note_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [7:0]    tick_q, tick_d;
  logic [7:0]    seg_len;
  logic          seg_done;
  logic          restart;
  logic          rep;
  logic          tone;
  note_t         cur;

`ifdef ALARM_REPEAT_EN
  assign rep = repeat_i;
`else
  logic unused_repeat;
  assign unused_repeat = repeat_i;
  assign rep = 1'b0;
`endif

  assign cur      = MELODY[note_q];
  assign seg_len  = (state_q == PLAY) ? {4'd0, cur.dur} : GAP_LEN;
  assign seg_done = (seg_len == 8'd0) ||
                    ((cyc_q == CYC_LAST) && (tick_q == seg_len - 8'd1));

  // restart marks every edge that begins a new segment, so all counters start from zero
  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    restart = 1'b0;
    if (stop) begin
      state_d = IDLE;
      note_d  = 3'd0;
      restart = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = PLAY;
            note_d  = 3'd0;
            restart = 1'b1;
          end
        end
        PLAY: begin
          if (seg_done) begin
            restart = 1'b1;
            if ((note_q == 3'd7) && !rep) begin
              state_d = IDLE;
              note_d  = 3'd0;
            end else if (GAP_TICKS == 0) begin
              note_d = note_q + 3'd1;
            end else begin
              state_d = GAP;
            end
          end
        end
        GAP: begin
          if (seg_done) begin
            state_d = PLAY;
            note_d  = note_q + 3'd1;
            restart = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          note_d  = 3'd0;
          restart = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    cyc_d  = cyc_q;
    tick_d = tick_q;
    if (restart || (state_q == IDLE)) begin
      cyc_d  = '0;
      tick_d = '0;
    end else if (cyc_q == CYC_LAST) begin
      cyc_d  = '0;
      tick_d = tick_q + 8'd1;
    end else begin
      cyc_d = cyc_q + 1'b1;
    end
  end

  always_ff @(posedge CLK_org) begin
    if (RST) begin
      state_q <= IDLE;
      note_q  <= 3'd0;
      cyc_q   <= '0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      cyc_q   <= cyc_d;
      tick_q  <= tick_d;
    end
  end

  alarm_tone_gen u_tone (
    .clk_i      (CLK_org),
    .rst_i      (RST),
    .clr_i      (restart),
    .en_i       (state_q == PLAY),
    .half_div_i (cur.half_div),
    .tone_o     (tone)
  );

  assign Speaker  = tone & ~mute & (state_q == PLAY);
  assign busy     = (state_q != IDLE);
  assign note_idx = note_q;

endmodule

// File: tb/tb_bottle_alarm.sv
// Bench for bottle_alarm: a timeline model (offset within the current note) checked every cycle,
// plus literal timing expectations for the first tone edge, note boundaries, stop, RST and repeat.
module tb_bottle_alarm;

  localparam int TD = 1000;
  localparam int GT = 1;
`ifdef ALARM_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       CLK_org = 1'b0;
  logic       RST = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       mute = 1'b0;
  logic       repeat_i = 1'b0;
  logic       Speaker;
  logic       busy;
  logic [2:0] note_idx;

  int n_vec = 0;
  int n_err = 0;

  int hd [8] = '{191, 170, 151, 143, 127, 113, 101, 0};
  int du [8] = '{2, 2, 2, 2, 2, 2, 2, 4};

  always #5 CLK_org = ~CLK_org;

  bottle_alarm #(.TICK_DIV(TD), .GAP_TICKS(GT)) dut (
    .CLK_org  (CLK_org),
    .RST      (RST),
    .start    (start),
    .stop     (stop),
    .mute     (mute),
    .repeat_i (repeat_i),
    .Speaker  (Speaker),
    .busy     (busy),
    .note_idx (note_idx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int tone_at(input int off, input int h);
    if (h == 0) return 0;
    return (off / h) % 2;
  endfunction

  // Model: whether a melody is active, which note, whether in the inter-note gap,
  // and cycles elapsed since the current segment began.
  bit m_act = 1'b0;
  bit m_gap = 1'b0;
  int m_note = 0;
  int m_off = 0;

  always @(posedge CLK_org) begin
    int len;
    if (RST || stop) begin
      m_act = 1'b0; m_gap = 1'b0; m_note = 0; m_off = 0;
    end else if (!m_act) begin
      if (start) begin
        m_act = 1'b1; m_gap = 1'b0; m_note = 0; m_off = 0;
      end
    end else begin
      m_off++;
      len = (m_gap ? GT : du[m_note]) * TD;
      if (m_off >= len) begin
        m_off = 0;
        if (m_gap) begin
          m_gap = 1'b0;
          m_note = (m_note + 1) % 8;
        end else if (m_note == 7 && !(REP_EN && repeat_i)) begin
          m_act = 1'b0;
          m_note = 0;
        end else if (GT == 0) begin
          m_note = (m_note + 1) % 8;
        end else begin
          m_gap = 1'b1;
        end
      end
    end
  end

  always @(posedge CLK_org) begin
    #1;
    check("busy", busy, 32'(m_act));
    check("note_idx", note_idx, 32'(m_note));
    check("speaker", Speaker,
          32'((m_act && !m_gap && tone_at(m_off, hd[m_note]) == 1 && !mute) ? 1 : 0));
  end

  task automatic start_pulse();
    @(negedge CLK_org) start = 1'b1;
    @(negedge CLK_org) start = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge CLK_org);
    check("rst_speaker", Speaker, 0);
    check("rst_busy", busy, 0);
    check("rst_note", note_idx, 0);
    RST = 1'b0;
    @(negedge CLK_org);

    // Run A: normal melody, random mute and ignored start pulses while busy
    start_pulse();
    check("A_busy_k1", busy, 1);
    check("A_note0", note_idx, 0);
    for (int n = 1; n <= 25000; n++) begin
      @(negedge CLK_org);
      start = 1'b0;
      if (n == 190)   check("A_spk_before_rise", Speaker, 0);
      if (n == 191)   check("A_spk_first_rise", Speaker, 1);
      if (n == 4501)  check("A_start_ignored_note", note_idx, 1);
      if (n == 20999) check("A_gap6_note", note_idx, 6);
      if (n == 21000) check("A_note7_entry", note_idx, 7);
      if (n == 24999) check("A_busy_last", busy, 1);
      if (n == 25000) check("A_busy_fall", busy, 0);
      if (n == 4500) start = 1'b1;
      if (n > 400 && n < 24900) begin
        mute = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 499) == 0) start = 1'b1;
      end else begin
        mute = 1'b0;
      end
    end

    // Run B: muted throughout with repeat requested
    mute = 1'b1;
    repeat_i = 1'b1;
    start_pulse();
    check("B_busy_k1", busy, 1);
    for (int n = 1; n <= 27000; n++) begin
      @(negedge CLK_org);
      if (n == 191)   check("B_spk_muted", Speaker, 0);
      if (n == 24999) check("B_busy_last", busy, 1);
      if (n == 25000) check("B_busy_end", busy, 32'(REP_EN));
      if (REP_EN && n == 25999) check("B_rep_gap_busy", busy, 1);
      if (REP_EN && n == 26000) check("B_rep_note0", note_idx, 0);
      if (REP_EN && n == 26000) check("B_rep_busy", busy, 1);
    end
    repeat_i = 1'b0;
    mute = 1'b0;
    @(negedge CLK_org) stop = 1'b1;
    @(negedge CLK_org) stop = 1'b0;
    check("B_stop_busy", busy, 0);

    // Run C: stop 500 cycles into note 3, start+stop together, replay, then RST mid-melody
    start_pulse();
    for (int n = 1; n <= 9500; n++) begin
      @(negedge CLK_org);
      if (n == 9000) check("C_note3_entry", note_idx, 3);
    end
    stop = 1'b1;
    @(negedge CLK_org) stop = 1'b0;
    check("C_stop_busy", busy, 0);
    check("C_stop_note", note_idx, 0);
    check("C_stop_spk", Speaker, 0);

    start = 1'b1;
    stop = 1'b1;
    @(negedge CLK_org);
    start = 1'b0;
    stop = 1'b0;
    check("C_start_stop_busy", busy, 0);

    start_pulse();
    check("C_replay_busy", busy, 1);
    check("C_replay_note", note_idx, 0);
    for (int n = 1; n <= 3000; n++) begin
      @(negedge CLK_org);
      if (n == 191) check("C_replay_rise", Speaker, 1);
    end
    RST = 1'b1;
    @(negedge CLK_org) RST = 1'b0;
    check("C_rst_busy", busy, 0);
    check("C_rst_note", note_idx, 0);
    check("C_rst_spk", Speaker, 0);

    repeat (20) @(negedge CLK_org);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bottle_alarm.md
BOTTLE_ALARM -- requirements
Module: bottle_alarm

Interface
REQ-001 Parameter TICK_DIV, default 50000: CLK_org cycles per duration tick.
REQ-002 Parameter GAP_TICKS, default 2: silent ticks inserted between consecutive notes.
REQ-003 The clock is CLK_org; the reset is RST, synchronous and active-high.
REQ-004 CLK_org  input  1: the only clock; all state updates on its rising edge.
REQ-005 RST  input  1: synchronous, active-high reset.
REQ-006 start  input  1: one-cycle pulse from the bottle controller when the fill target is reached.
REQ-007 stop  input  1: abort request (operator key).
REQ-008 mute  input  1: level; silences Speaker without halting sequencing.
REQ-009 repeat  input  1: level; loop request, used only per REQ-030.
REQ-010 Speaker  output  1: square-wave tone to the buzzer.
REQ-011 busy  output  1: high while a melody is in progress.
REQ-012 note_idx  output  3: index of the current note, 0-7.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, PLAY and GAP.
REQ-014 In IDLE: Speaker=0, busy=0, note_idx=0.
REQ-015 start=1 sampled in IDLE at edge k SHALL enter PLAY with note_idx=0; busy=1 from edge k+1.
REQ-016 start while busy=1 SHALL be ignored.
REQ-017 A melody is 8 notes; each table entry holds half_div (16-bit) and dur (4-bit ticks).
REQ-018 The tick counter and tone counter SHALL clear on entry to every PLAY and GAP state.
REQ-019 In PLAY, Speaker SHALL toggle every half_div cycles; the first toggle occurs half_div cycles after entry.
REQ-020 An entry with half_div=0 is a rest; Speaker SHALL hold 0 for that note.
REQ-021 PLAY SHALL last exactly dur*TICK_DIV cycles, then go to GAP, or to IDLE after note 7.
REQ-022 GAP SHALL hold Speaker=0 for exactly GAP_TICKS*TICK_DIV cycles, then enter PLAY with note_idx+1.
REQ-023 GAP_TICKS=0 SHALL skip GAP entirely, so PLAY follows PLAY directly.
REQ-024 Total busy time SHALL be (sum of dur + 7*GAP_TICKS)*TICK_DIV cycles.
REQ-025 stop=1 in any state SHALL force IDLE at the next edge, with Speaker=0 and busy=0.
REQ-026 If start and stop are both high in IDLE, stop wins and the FSM stays in IDLE.
REQ-027 mute=1 SHALL force Speaker=0 combinationally from the internal tone; timing and note_idx are unaffected.

Reset
REQ-028 RST=1 SHALL return the block to IDLE with all counters 0 and Speaker=0, busy=0, note_idx=0, including mid-melody.
REQ-029 RST SHALL take precedence over start and stop.

Configuration
REQ-030 With ALARM_REPEAT_EN defined: at the end of note 7, if repeat=1, the FSM enters GAP and then restarts at note_idx=0 with busy held high; if repeat=0, it goes to IDLE.
REQ-031 Without ALARM_REPEAT_EN: repeat is ignored and the melody always ends in IDLE after note 7.

Structure
REQ-032 Package bottle_alarm_pkg SHALL hold the FSM state enum, the note-entry struct and the 8-entry melody constant.
REQ-033 Melody half_div values: 191,170,151,143,127,113,101,0.
REQ-034 Melody dur values: 2,2,2,2,2,2,2,4.
REQ-035 Sub-module alarm_tone_gen SHALL implement the clearable half_div toggle counter used by REQ-019 and REQ-020.

Verification
REQ-036 TICK_DIV=1000, GAP_TICKS=1; start pulse at edge k -> busy=1 at k+1, note_idx=0, Speaker first rises at k+1+191, and busy falls at k+1+25000.
REQ-037 Same setup, note 7 (rest) -> Speaker=0 for all 4000 cycles of the note; note_idx=7 throughout.
REQ-038 stop pulse 500 cycles into note 3 -> IDLE, Speaker=0, busy=0, note_idx=0 at the next edge; a later start replays from note 0.
REQ-039 mute=1 for the whole melody -> Speaker stays 0; busy still falls at k+1+25000.
REQ-040 start pulsed while busy, and start with stop in the same IDLE cycle -> both ignored; RST at cycle 3000 -> all outputs 0 at the next edge.
REQ-041 ALARM_REPEAT_EN defined, repeat=1 -> after note 7 there is a 1000-cycle gap, then note_idx=0 with busy continuously high; with repeat=0, busy falls at k+1+25000.
